// File: rtl/mul_fp_pkg.sv
// Shared constants and encodings for the floating-point multiplier datapath.
// Rounding-mode codes travel alongside the significand toward the rounder.
package mul_fp_pkg;

   typedef enum logic [1:0] {
      TO_NEAR = 2'b00,
      TO_ZERO = 2'b01,
      TO_PINF = 2'b10,
      TO_NINF = 2'b11
   } rmode_e;

   localparam int PROD_W = 48;
   localparam int MANT_W = 24;
   localparam int EXP_W  = 8;
   localparam int BIAS   = 127;
   localparam int LZ_W   = 6;

endpackage

// File: rtl/lzc48.sv
// Leading-zero counter for the 48-bit significand product.
// Count is 48 when the input is all zeros.
module lzc48
   import mul_fp_pkg::*;
(
   input  logic [PROD_W-1:0] i_data,
   output logic [LZ_W-1:0]   o_cnt,
   output logic              o_zero
);

   // Ascending scan: the highest set bit is the last to write the count.
   always_comb begin
      o_cnt = LZ_W'(PROD_W);
      for (int i = 0; i < PROD_W; i++) begin
         if (i_data[i]) begin
            o_cnt = LZ_W'(PROD_W - 1 - i);
         end
      end
   end

   assign o_zero = ~|i_data;

endmodule

// File: rtl/mul_normalize.sv
// Two-stage normalizer for the raw significand product of an FP multiply.
// Stage 1 captures operands with leading-zero count; stage 2 shifts and flags.
module mul_normalize
   import mul_fp_pkg::*;
#(
   parameter int PROD_W   = 48,
   parameter int EXP_IN_W = 10
)(
   input  logic                CLK,
   input  logic                RST,
   input  logic                in_valid,
   input  logic [PROD_W-1:0]   Prod,
   input  logic [EXP_IN_W-1:0] Exp_in,
   input  logic                Sign_in,
   input  logic [1:0]          R_mode_in,
   output logic [MANT_W:0]     After_norm,
   output logic                T,
   output logic                Sz,
   output logic [1:0]          R_mode_ext,
   output logic [EXP_W-1:0]    Exp_out,
   output logic                out_valid,
   output logic                Zero,
   output logic                Tiny,
   output logic                Exp_ovf
);

   localparam int E_W = EXP_IN_W + 1;
   localparam int T_W = PROD_W - MANT_W - 1;

   // Stage 1 registers
   logic                r_s1_valid;
   logic [PROD_W-1:0]   r_prod;
   logic [EXP_IN_W-1:0] r_exp_in;
   logic                r_sign;
   rmode_e              r_rmode;
   logic [LZ_W-1:0]     r_lz;
   logic                r_zero;

   // Stage 2 registers
   logic                r_out_valid;
   logic [MANT_W:0]     r_after_norm;
   logic                r_t;
   logic [EXP_W-1:0]    r_exp_out;
   logic                r_zero_flag;
   logic                r_tiny;
   logic                r_ovf;

   logic [LZ_W-1:0]       w_lz;
   logic                  w_zero;
   logic signed [E_W-1:0] w_e;
   logic                  w_sub;
   logic                  w_ovf;
   logic                  w_exp_neg;
   logic [EXP_IN_W-1:0]   w_shr_n;
   logic                  w_shr_big;
   logic [LZ_W-1:0]       w_shl_amt;
   logic [PROD_W-1:0]     w_shl;
   logic [2*PROD_W-1:0]   w_wide;
   logic [PROD_W-1:0]     w_sig;
   logic                  w_sticky;
   logic [MANT_W:0]       w_an_next;
   logic                  w_t_next;
   logic [EXP_W-1:0]      w_exp_next;

   lzc48 u_lzc (
      .i_data (Prod),
      .o_cnt  (w_lz),
      .o_zero (w_zero)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_s1_valid <= 1'b0;
         r_prod     <= '0;
         r_exp_in   <= '0;
         r_sign     <= 1'b0;
         r_rmode    <= TO_NEAR;
         r_lz       <= '0;
         r_zero     <= 1'b0;
      end else begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_prod   <= Prod;
            r_exp_in <= Exp_in;
            r_sign   <= Sign_in;
            r_rmode  <= rmode_e'(R_mode_in);
            r_lz     <= w_lz;
            r_zero   <= w_zero;
         end
      end
   end

   // Unbiased-to-field exponent after normalization; wide enough never to wrap.
   assign w_e = $signed({r_exp_in[EXP_IN_W-1], r_exp_in})
              + $signed(E_W'(1))
              - $signed({{(E_W-LZ_W){1'b0}}, r_lz});

   assign w_sub     = w_e[E_W-1] | (w_e == '0);
   assign w_ovf     = ~w_e[E_W-1] & (w_e[E_W-2:0] >= (E_W-1)'(255));
   assign w_exp_neg = r_exp_in[EXP_IN_W-1];

   // Magnitude of a negative exponent sum read as unsigned (covers the most negative code).
   assign w_shr_n   = '0 - r_exp_in;
   assign w_shr_big = (w_shr_n >= EXP_IN_W'(PROD_W));

   // A subnormal with non-negative Exp_in always has Exp_in < lz, so it fits the lz width.
   assign w_shl_amt = w_sub ? r_exp_in[LZ_W-1:0] : r_lz;
   assign w_shl     = r_prod << w_shl_amt;
   assign w_wide    = {r_prod, {PROD_W{1'b0}}} >> w_shr_n[LZ_W-1:0];

   always_comb begin
      w_sig    = '0;
      w_sticky = 1'b0;
      if (r_zero) begin
         w_sig    = '0;
         w_sticky = 1'b0;
      end else if (w_sub && w_exp_neg) begin
         if (w_shr_big) begin
            w_sticky = 1'b1;
         end else begin
            w_sig    = w_wide[2*PROD_W-1:PROD_W];
            w_sticky = |w_wide[PROD_W-1:0];
         end
      end else begin
         w_sig = w_shl;
      end
   end

   assign w_an_next  = w_sig[PROD_W-1 -: MANT_W+1];
   assign w_t_next   = (|w_sig[T_W-1:0]) | w_sticky;
   assign w_exp_next = (r_zero || w_sub) ? '0 : w_e[EXP_W-1:0];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_out_valid  <= 1'b0;
         r_after_norm <= '0;
         r_t          <= 1'b0;
         r_exp_out    <= '0;
         r_zero_flag  <= 1'b0;
         r_tiny       <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_after_norm <= w_an_next;
            r_t          <= w_t_next;
            r_exp_out    <= w_exp_next;
            r_zero_flag  <= r_zero;
            r_tiny       <= ~r_zero & w_sub;
            r_ovf        <= ~r_zero & w_ovf;
         end
      end
   end

   // Sign and rounding mode leave from stage 1 so the rounder's register lines them up.
   assign Sz         = r_sign;
   assign R_mode_ext = r_rmode;
   assign After_norm = r_after_norm;
   assign T          = r_t;
   assign Exp_out    = r_exp_out;
   assign out_valid  = r_out_valid;
   assign Zero       = r_zero_flag;
   assign Tiny       = r_tiny;
   assign Exp_ovf    = r_ovf;

endmodule

// File: tb/tb_mul_normalize.sv
// Self-checking bench for mul_normalize: directed corner vectors plus randomized
// traffic checked against an arithmetic model of the normalization rules.
module tb_mul_normalize;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        in_valid = 1'b0;
   logic [47:0] Prod = '0;
   logic [9:0]  Exp_in = '0;
   logic        Sign_in = 1'b0;
   logic [1:0]  R_mode_in = '0;
   logic [24:0] After_norm;
   logic        T, Sz, out_valid, Zero, Tiny, Exp_ovf;
   logic [1:0]  R_mode_ext;
   logic [7:0]  Exp_out;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic        v;
      logic [24:0] an;
      logic        t;
      logic [7:0]  eo;
      logic        z;
      logic        ti;
      logic        ov;
   } res_t;

   typedef struct {
      logic [47:0] p;
      int          e;
      res_t        r;
   } vec_t;

   res_t last_res = '0;
   vec_t vecs[$];

   mul_normalize dut (
      .CLK        (CLK),
      .RST        (RST),
      .in_valid   (in_valid),
      .Prod       (Prod),
      .Exp_in     (Exp_in),
      .Sign_in    (Sign_in),
      .R_mode_in  (R_mode_in),
      .After_norm (After_norm),
      .T          (T),
      .Sz         (Sz),
      .R_mode_ext (R_mode_ext),
      .Exp_out    (Exp_out),
      .out_valid  (out_valid),
      .Zero       (Zero),
      .Tiny       (Tiny),
      .Exp_ovf    (Exp_ovf)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Value-level model: scale Prod by powers of two, remainder feeds the sticky bit.
   function automatic res_t model(input logic [47:0] p, input int e);
      res_t r;
      int msb, lz, ee, n;
      logic [127:0] q, rem, den;
      r = '0;
      r.v = 1'b1;
      rem = '0;
      if (p == 48'd0) begin
         r.z = 1'b1;
         return r;
      end
      msb = 47;
      while (p[msb] == 1'b0) msb--;
      lz = 47 - msb;
      ee = e + 1 - lz;
      if (ee >= 1) begin
         q = 128'(p) * (128'd1 << lz);
         r.ov = (ee >= 255);
         r.eo = r.ov ? 8'h00 : ee[7:0];
      end else begin
         r.ti = 1'b1;
         if (e >= 0) begin
            q = 128'(p) * (128'd1 << e);
         end else begin
            n = -e;
            if (n >= 100) begin
               q = '0;
               rem = 128'(p);
            end else begin
               den = 128'd1 << n;
               q = 128'(p) / den;
               rem = 128'(p) % den;
            end
         end
      end
      r.an = q[47:23];
      r.t = (|q[22:0]) || (rem != 0);
      return r;
   endfunction

   function automatic res_t snap();
      return {out_valid, After_norm, T, Exp_out, Zero, Tiny, Exp_ovf};
   endfunction

   function automatic logic [47:0] rand_prod();
      logic [47:0] p;
      p = 48'({$urandom(), $urandom()});
      p = p >> $urandom_range(0, 48);
      if ($urandom_range(0, 11) == 0) p = '0;
      return p;
   endfunction

   function automatic int rand_exp();
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 1023)) - 512;
      return int'($urandom_range(0, 320)) - 60;
   endfunction

   function automatic void add_vec(input logic [47:0] p, input int e, input logic [24:0] an,
                                   input logic t, input logic [7:0] eo,
                                   input logic z, input logic ti, input logic ov);
      vec_t x;
      x.p = p;
      x.e = e;
      x.r = {1'b1, an, t, eo, z, ti, ov};
      vecs.push_back(x);
   endfunction

   task automatic test_reset();
      #1 RST = 1'b0;
      in_valid = 1'b1;
      Prod = 48'h800000000000;
      Exp_in = 10'd127;
      Sign_in = 1'b1;
      R_mode_in = 2'b11;
      #1;
      n_cmp++;
      if ({snap(), Sz, R_mode_ext} !== '0) begin
         n_bad++;
         $display("FAIL reset_async: got %h required 0", {snap(), Sz, R_mode_ext});
      end
      @(posedge CLK); #1;
      n_cmp++;
      if ({snap(), Sz, R_mode_ext} !== '0) begin
         n_bad++;
         $display("FAIL reset_held: got %h required 0", {snap(), Sz, R_mode_ext});
      end
      in_valid = 1'b0;
      RST = 1'b1;
      last_res = '0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      n_cmp++;
      if ({snap(), Sz, R_mode_ext} !== '0) begin
         n_bad++;
         $display("FAIL reset_release_idle: got %h required 0", {snap(), Sz, R_mode_ext});
      end
   endtask

   task automatic test_directed();
      res_t got, exp;
      logic s;
      logic [1:0] m;
      add_vec(48'h800000000000,  127, 25'h1000000, 1'b0, 8'd128, 1'b0, 1'b0, 1'b0);
      add_vec(48'h400000000001,  127, 25'h1000000, 1'b1, 8'd127, 1'b0, 1'b0, 1'b0);
      add_vec(48'h000000000000,  200, 25'h0000000, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0);
      add_vec(48'h800000000000,   -2, 25'h0400000, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
      add_vec(48'h800000000000,  -60, 25'h0000000, 1'b1, 8'd0,   1'b0, 1'b1, 1'b0);
      add_vec(48'h800000000000,  300, 25'h1000000, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1);
      add_vec(48'h800000000000,    0, 25'h1000000, 1'b0, 8'd1,   1'b0, 1'b0, 1'b0);
      add_vec(48'h400000000000,    0, 25'h0800000, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
      add_vec(48'h800000000000,  254, 25'h1000000, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1);
      add_vec(48'h800000000000,  253, 25'h1000000, 1'b0, 8'd254, 1'b0, 1'b0, 1'b0);
      add_vec(48'h800000000000,  -47, 25'h0000000, 1'b1, 8'd0,   1'b0, 1'b1, 1'b0);
      add_vec(48'hFFFFFFFFFFFF,  -23, 25'h0000003, 1'b1, 8'd0,   1'b0, 1'b1, 1'b0);
      add_vec(48'h000000000001,   10, 25'h0000000, 1'b1, 8'd0,   1'b0, 1'b1, 1'b0);
      add_vec(48'h000001000000,    5, 25'h0000040, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
      add_vec(48'h000000000000, -512, 25'h0000000, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0);
      add_vec(48'h000000800000,  100, 25'h1000000, 1'b0, 8'd77,  1'b0, 1'b0, 1'b0);
      foreach (vecs[i]) begin
         s = 1'($urandom);
         m = 2'($urandom);
         in_valid = 1'b1;
         Prod = vecs[i].p;
         Exp_in = vecs[i].e[9:0];
         Sign_in = s;
         R_mode_in = m;
         @(posedge CLK); #1;
         in_valid = 1'b0;
         Prod = rand_prod();
         Exp_in = 10'($urandom);
         Sign_in = ~s;
         R_mode_in = ~m;
         n_cmp++;
         if ({out_valid, Sz, R_mode_ext} !== {1'b0, s, m}) begin
            n_bad++;
            $display("FAIL dir%0d_stage1 {valid,Sz,mode}: got %b required %b",
                     i, {out_valid, Sz, R_mode_ext}, {1'b0, s, m});
         end
         @(posedge CLK); #1;
         exp = vecs[i].r;
         got = snap();
         if (exp.ov) got.eo = 8'h00;
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL dir%0d_out: got %h required %h", i, got, exp);
         end
         @(posedge CLK); #1;
         exp.v = 1'b0;
         got = snap();
         if (exp.ov) got.eo = 8'h00;
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL dir%0d_hold: got %h required %h", i, got, exp);
         end
         last_res = vecs[i].r;
      end
   endtask

   task automatic test_random();
      res_t got, exp;
      logic v, s, pv;
      logic [1:0] m;
      logic [47:0] p, pp;
      int e, pe;
      pv = 1'b0;
      pp = '0;
      pe = 0;
      for (int i = 0; i < 302; i++) begin
         v = (i < 300) && ($urandom_range(0, 9) < 7);
         p = rand_prod();
         e = rand_exp();
         s = 1'($urandom);
         m = 2'($urandom);
         in_valid = v;
         Prod = p;
         Exp_in = e[9:0];
         Sign_in = s;
         R_mode_in = m;
         @(posedge CLK); #1;
         if (v) begin
            n_cmp++;
            if ({Sz, R_mode_ext} !== {s, m}) begin
               n_bad++;
               $display("FAIL rnd%0d_sz_mode: got %b required %b", i, {Sz, R_mode_ext}, {s, m});
            end
         end
         if (pv) begin
            exp = model(pp, pe);
            last_res = exp;
         end else begin
            exp = last_res;
            exp.v = 1'b0;
         end
         got = snap();
         if (exp.ov) got.eo = 8'h00;
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL rnd%0d_out (prod=%h exp=%0d): got %h required %h", i, pp, pe, got, exp);
         end
         pv = v;
         pp = p;
         pe = e;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      res_t got, exp;
      logic [47:0] p, pp;
      int e, pe;
      pp = '0;
      pe = 0;
      for (int i = 0; i < 26; i++) begin
         p = (i % 5 == 2) ? 48'd0 : rand_prod();
         e = rand_exp();
         in_valid = (i < 25);
         Prod = p;
         Exp_in = e[9:0];
         Sign_in = 1'($urandom);
         R_mode_in = 2'($urandom);
         @(posedge CLK); #1;
         if (i >= 1) begin
            exp = model(pp, pe);
            last_res = exp;
            got = snap();
            if (exp.ov) got.eo = 8'h00;
            n_cmp++;
            if (got !== exp) begin
               n_bad++;
               $display("FAIL b2b%0d_out (prod=%h exp=%0d): got %h required %h", i, pp, pe, got, exp);
            end
         end
         pp = p;
         pe = e;
      end
      in_valid = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_reset_midflight();
      res_t got, exp_a, exp_c;
      exp_a = model(48'h800000000000, 127);
      exp_c = model(48'h123456789ABC, 50);
      in_valid = 1'b1;
      Prod = 48'h800000000000;
      Exp_in = 10'd127;
      Sign_in = 1'b0;
      R_mode_in = 2'b01;
      @(posedge CLK); #1;
      Prod = 48'h400000000001;
      Sign_in = 1'b1;
      R_mode_in = 2'b10;
      @(posedge CLK); #1;
      got = snap();
      n_cmp++;
      if (got !== exp_a) begin
         n_bad++;
         $display("FAIL mid_first_out: got %h required %h", got, exp_a);
      end
      Prod = 48'h123456789ABC;
      Exp_in = 10'd50;
      Sign_in = 1'b1;
      R_mode_in = 2'b11;
      #1 RST = 1'b0;
      #1;
      n_cmp++;
      if ({snap(), Sz, R_mode_ext} !== '0) begin
         n_bad++;
         $display("FAIL mid_async_clear: got %h required 0", {snap(), Sz, R_mode_ext});
      end
      #1 RST = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      n_cmp++;
      if ({snap(), Sz, R_mode_ext} !== {38'd0, 1'b1, 2'b11}) begin
         n_bad++;
         $display("FAIL mid_discard: got %h required %h",
                  {snap(), Sz, R_mode_ext}, {38'd0, 1'b1, 2'b11});
      end
      @(posedge CLK); #1;
      got = snap();
      if (exp_c.ov) got.eo = 8'h00;
      n_cmp++;
      if (got !== exp_c) begin
         n_bad++;
         $display("FAIL mid_after_release: got %h required %h", got, exp_c);
      end
      @(posedge CLK); #1;
      exp_c.v = 1'b0;
      got = snap();
      if (exp_c.ov) got.eo = 8'h00;
      n_cmp++;
      if (got !== exp_c) begin
         n_bad++;
         $display("FAIL mid_single_pulse: got %h required %h", got, exp_c);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
